// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: channel FSM state encoding
// and the helper that sizes requester index fields.
package sram_port_arbiter_pkg;

    // Channel FSM states; IDLE waits for a request, BUSY holds the SRAM request until ack.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Width of a requester index; at least one bit so two requesters still get a field.
    function automatic int req_idx_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Synchronous FIFO of requester index tags for reads that are in flight at the SRAM.
// The head tag is visible combinationally so returned data can be steered in the
// cycle it arrives. A push and pop in the same cycle are both honoured, even when full.
module sram_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] head_tag_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_eff;
    logic             pop_eff;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign head_tag_o = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a push while full only lands if a pop frees the slot.
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);

    // Next pointer and occupancy values from the effective push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_eff && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (pop_eff && !push_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    // Tag storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO and drops in-flight tags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single SRAM write channel and read channel between NUM_REQ requesters.
// Each channel runs its own two-state round-robin arbiter; read winners are queued
// in a tag FIFO so returned data is flagged to the requester that issued it.
// Optional feature macro: SRAM_ARB_STATS_EN enables the per-requester grant counters;
// without it grant_cnt_o is tied to zero.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int RD_TAG_DEPTH    = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0] req_wr_addr_i,
    input  logic [NUM_REQ*SRAM_DATA_WIDTH-1:0] req_wr_data_i,
    input  logic [NUM_REQ-1:0]                 req_wr_req_i,
    output logic [NUM_REQ-1:0]                 req_wr_ack_o,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0] req_rd_addr_i,
    input  logic [NUM_REQ-1:0]                 req_rd_req_i,
    output logic [NUM_REQ-1:0]                 req_rd_ack_o,
    output logic [NUM_REQ-1:0]                 req_rd_vld_o,
    output logic [SRAM_DATA_WIDTH-1:0]         req_rd_data_o,
    output logic [SRAM_ADDR_WIDTH-1:0]         wr_0_addr_o,
    output logic [SRAM_DATA_WIDTH-1:0]         wr_0_data_o,
    output logic                               wr_0_req_o,
    input  logic                               wr_0_ack_i,
    output logic [SRAM_ADDR_WIDTH-1:0]         rd_0_addr_o,
    output logic                               rd_0_req_o,
    input  logic                               rd_0_ack_i,
    input  logic                               rd_0_vld_i,
    input  logic [SRAM_DATA_WIDTH-1:0]         rd_0_data_i,
    output logic                               tag_err_o,
    output logic [NUM_REQ*32-1:0]              grant_cnt_o
);

    localparam int IDX_W = req_idx_width(NUM_REQ);

    arb_state_e       wr_state_q;
    arb_state_e       wr_state_d;
    arb_state_e       rd_state_q;
    arb_state_e       rd_state_d;
    logic [IDX_W-1:0] wr_win_q;
    logic [IDX_W-1:0] wr_win_d;
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] wr_ptr_d;
    logic [IDX_W-1:0] rd_win_q;
    logic [IDX_W-1:0] rd_win_d;
    logic [IDX_W-1:0] rd_ptr_q;
    logic [IDX_W-1:0] rd_ptr_d;
    logic             wr_busy;
    logic             rd_busy;
    logic             tag_push;
    logic             tag_full;
    logic             tag_empty;
    logic [IDX_W-1:0] tag_head;
    logic             rd_steer;
    logic             tag_err_q;

    // Lowest set request at or above the pointer, otherwise the lowest set request overall.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel_hi;
        logic [IDX_W-1:0] sel_lo;
        logic             found_hi;
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_lo = IDX_W'(i);
            end
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                sel_hi   = IDX_W'(i);
                found_hi = 1'b1;
            end
        end
        return found_hi ? sel_hi : sel_lo;
    endfunction

    // Pointer moves one past the requester just served, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] win);
        if (win == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return win + 1'b1;
    endfunction

    assign wr_busy = (wr_state_q == ARB_BUSY);
    assign rd_busy = (rd_state_q == ARB_BUSY);

    // State, winner and pointer registers for both channels; reset aborts any access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_state_q <= ARB_IDLE;
            wr_win_q   <= '0;
            wr_ptr_q   <= '0;
            rd_state_q <= ARB_IDLE;
            rd_win_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_win_q   <= wr_win_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_state_q <= rd_state_d;
            rd_win_q   <= rd_win_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Write channel next state: latch a winner in IDLE, release and advance the pointer on ack.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_win_d   = wr_win_q;
        wr_ptr_d   = wr_ptr_q;
        if (wr_state_q == ARB_IDLE) begin
            if (|req_wr_req_i) begin
                wr_win_d   = rr_pick(req_wr_req_i, wr_ptr_q);
                wr_state_d = ARB_BUSY;
            end
        end else begin
            if (wr_0_ack_i) begin
                wr_ptr_d   = next_ptr(wr_win_q);
                wr_state_d = ARB_IDLE;
            end
        end
    end

    // Read channel next state: same as write, but no new grant while every tag slot is in use.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_win_d   = rd_win_q;
        rd_ptr_d   = rd_ptr_q;
        if (rd_state_q == ARB_IDLE) begin
            if ((|req_rd_req_i) && !tag_full) begin
                rd_win_d   = rr_pick(req_rd_req_i, rd_ptr_q);
                rd_state_d = ARB_BUSY;
            end
        end else begin
            if (rd_0_ack_i) begin
                rd_ptr_d   = next_ptr(rd_win_q);
                rd_state_d = ARB_IDLE;
            end
        end
    end

    // Write channel outputs: SRAM bus carries the winner's slice only while BUSY.
    always_comb begin
        wr_0_req_o  = 1'b0;
        wr_0_addr_o = '0;
        wr_0_data_o = '0;
        if (wr_busy) begin
            wr_0_req_o  = 1'b1;
            wr_0_addr_o = req_wr_addr_i[int'(wr_win_q)*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
            wr_0_data_o = req_wr_data_i[int'(wr_win_q)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
        end
    end

    // Read channel outputs: SRAM read address carries the winner's slice only while BUSY.
    always_comb begin
        rd_0_req_o  = 1'b0;
        rd_0_addr_o = '0;
        if (rd_busy) begin
            rd_0_req_o  = 1'b1;
            rd_0_addr_o = req_rd_addr_i[int'(rd_win_q)*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
        end
    end

    // An accepted read records its requester; returned data pops it in the same cycle.
    assign tag_push = rd_busy && rd_0_ack_i;
    assign rd_steer = rd_0_vld_i && !tag_empty;

    sram_arb_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH),
        .TAG_W (IDX_W)
    ) u_tag_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (tag_push),
        .push_tag_i (rd_win_q),
        .pop_i      (rd_0_vld_i),
        .head_tag_o (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    // Read data is shared by all requesters; it is zeroed unless it is steered to one of them.
    assign req_rd_data_o = rd_steer ? rd_0_data_i : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_wr_ack_o[gi] = wr_busy && wr_0_ack_i && (wr_win_q == IDX_W'(gi));
            assign req_rd_ack_o[gi] = rd_busy && rd_0_ack_i && (rd_win_q == IDX_W'(gi));
            assign req_rd_vld_o[gi] = rd_steer && (tag_head == IDX_W'(gi));
        end
    endgenerate

    // Sticky error: data came back with no read recorded as outstanding.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_err_q <= 1'b0;
        end else if (rd_0_vld_i && tag_empty) begin
            tag_err_q <= 1'b1;
        end
    end

    assign tag_err_o = tag_err_q;

`ifdef SRAM_ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [31:0] cnt_q;
            logic [31:0] cnt_d;

            // A write and a read grant in the same cycle both count.
            assign cnt_d = cnt_q + {31'b0, req_wr_ack_o[gi]} + {31'b0, req_rd_ack_o[gi]};

            // Free-running grant counter, wrapping at 2^32.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign grant_cnt_o[gi*32 +: 32] = cnt_q;
        end
    endgenerate
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with two requesters and default widths.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 19;
    localparam int DW = 72;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] req_wr_addr;
    logic [NR*DW-1:0] req_wr_data;
    logic [NR-1:0]    req_wr_req;
    logic [NR-1:0]    req_wr_ack;
    logic [NR*AW-1:0] req_rd_addr;
    logic [NR-1:0]    req_rd_req;
    logic [NR-1:0]    req_rd_ack;
    logic [NR-1:0]    req_rd_vld;
    logic [DW-1:0]    req_rd_data;
    logic [AW-1:0]    wr_0_addr;
    logic [DW-1:0]    wr_0_data;
    logic             wr_0_req;
    logic             wr_0_ack;
    logic [AW-1:0]    rd_0_addr;
    logic             rd_0_req;
    logic             rd_0_ack;
    logic             rd_0_vld;
    logic [DW-1:0]    rd_0_data;
    logic             tag_err;
    logic [NR*32-1:0] grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DW-1:0] WR_D0   = 72'h11_2233_4455_6677_8899;
    localparam logic [DW-1:0] WR_D1   = 72'h99_8877_6655_4433_2211;
    localparam logic [DW-1:0] RD_BASE = 72'hD0_0000_0000_0000_0000;

    sram_port_arbiter #(
        .NUM_REQ         (NR),
        .SRAM_ADDR_WIDTH (AW),
        .SRAM_DATA_WIDTH (DW),
        .RD_TAG_DEPTH    (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_wr_addr_i (req_wr_addr),
        .req_wr_data_i (req_wr_data),
        .req_wr_req_i  (req_wr_req),
        .req_wr_ack_o  (req_wr_ack),
        .req_rd_addr_i (req_rd_addr),
        .req_rd_req_i  (req_rd_req),
        .req_rd_ack_o  (req_rd_ack),
        .req_rd_vld_o  (req_rd_vld),
        .req_rd_data_o (req_rd_data),
        .wr_0_addr_o   (wr_0_addr),
        .wr_0_data_o   (wr_0_data),
        .wr_0_req_o    (wr_0_req),
        .wr_0_ack_i    (wr_0_ack),
        .rd_0_addr_o   (rd_0_addr),
        .rd_0_req_o    (rd_0_req),
        .rd_0_ack_i    (rd_0_ack),
        .rd_0_vld_i    (rd_0_vld),
        .rd_0_data_i   (rd_0_data),
        .tag_err_o     (tag_err),
        .grant_cnt_o   (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int r);
        return (r == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [AW-1:0] exp_wr_addr(input int r);
        return (r == 0) ? 19'h00010 : 19'h00020;
    endfunction

    function automatic logic [AW-1:0] exp_rd_addr(input int r);
        return (r == 0) ? 19'h00100 : 19'h00200;
    endfunction

    function automatic logic [DW-1:0] exp_wr_data(input int r);
        return (r == 0) ? WR_D0 : WR_D1;
    endfunction

    task automatic clear_inputs();
        req_wr_req = '0;
        req_rd_req = '0;
        wr_0_ack   = 1'b0;
        rd_0_ack   = 1'b0;
        rd_0_vld   = 1'b0;
        rd_0_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One write from requester r with the SRAM acking immediately; ends one cycle after the ack.
    task automatic wr_one(input int r);
        int n;
        n = 0;
        req_wr_req = onehot(r);
        wr_0_ack   = 1'b1;
        #1;
        while (req_wr_ack == 2'b00 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq($sformatf("wr_ack_r%0d", r), 128'(req_wr_ack), 128'(onehot(r)));
        check_eq("wr_addr", 128'(wr_0_addr), 128'(exp_wr_addr(r)));
        check_eq("wr_data", 128'(wr_0_data), 128'(exp_wr_data(r)));
        $display("wr grant req%0d addr=%0h", r, wr_0_addr);
        @(negedge clk);
        req_wr_req = '0;
        wr_0_ack   = 1'b0;
    endtask

    // One read from requester r with the SRAM acking immediately; ends one cycle after the ack.
    task automatic rd_one(input int r);
        int n;
        n = 0;
        req_rd_req = onehot(r);
        rd_0_ack   = 1'b1;
        #1;
        while (req_rd_ack == 2'b00 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq($sformatf("rd_ack_r%0d", r), 128'(req_rd_ack), 128'(onehot(r)));
        check_eq("rd_addr", 128'(rd_0_addr), 128'(exp_rd_addr(r)));
        $display("rd grant req%0d addr=%0h", r, rd_0_addr);
        @(negedge clk);
        req_rd_req = '0;
        rd_0_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev_ack;
        logic [1:0] exp_t2 [8];
        int         order [3];
        int         vld_at [3];
        int         issued;
        int         returned;
        bit         just_acked;

        reset       = 1'b1;
        req_wr_addr = {19'h00020, 19'h00010};
        req_wr_data = {WR_D1, WR_D0};
        req_rd_addr = {19'h00200, 19'h00100};
        clear_inputs();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_wr_req", 128'(wr_0_req), 128'(0));
        check_eq("rst_rd_req", 128'(rd_0_req), 128'(0));
        check_eq("rst_wr_addr", 128'(wr_0_addr), 128'(0));
        check_eq("rst_tag_err", 128'(tag_err), 128'(0));
        check_eq("rst_grant_cnt", 128'(grant_cnt), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // 1: requester 0 write, SRAM ack two cycles after its request rises
        req_wr_req = 2'b01;
        #1;
        check_eq("t1_idle_req", 128'(wr_0_req), 128'(0));
        @(negedge clk);
        #1;
        check_eq("t1_req", 128'(wr_0_req), 128'(1));
        check_eq("t1_addr", 128'(wr_0_addr), 128'(19'h00010));
        check_eq("t1_data", 128'(wr_0_data), 128'(WR_D0));
        check_eq("t1_noack", 128'(req_wr_ack), 128'(0));
        @(negedge clk);
        #1;
        check_eq("t1_hold", 128'(wr_0_req), 128'(1));
        @(negedge clk);
        wr_0_ack = 1'b1;
        #1;
        check_eq("t1_ack", 128'(req_wr_ack), 128'(2'b01));
        $display("t1 write req0 acked addr=%0h", wr_0_addr);
        @(negedge clk);
        wr_0_ack   = 1'b0;
        req_wr_req = '0;
        #1;
        check_eq("t1_release", 128'(wr_0_req), 128'(0));
        check_eq("t1_bus_zero", 128'(wr_0_addr), 128'(0));

        // 2: both requesters write continuously with ack held high
        do_reset();
        exp_t2   = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        prev_ack = 2'b00;
        wr_0_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_wr_req = ~prev_ack;
            #1;
            check_eq($sformatf("t2_ack%0d", k), 128'(req_wr_ack), 128'(exp_t2[k]));
            if (req_wr_ack != 2'b00) begin
                $display("t2 write grant ack=%b", req_wr_ack);
            end
            prev_ack = req_wr_ack;
            @(negedge clk);
        end
        req_wr_req = '0;
        wr_0_ack   = 1'b0;
        @(negedge clk);

        // 3: reads 0,1,0 with data returned 5 cycles after each ack
        order      = '{0, 1, 0};
        vld_at     = '{0, 0, 0};
        issued     = 0;
        returned   = 0;
        just_acked = 1'b0;
        rd_0_ack   = 1'b1;
        for (int c = 0; c < 16; c++) begin
            req_rd_req = (issued < 3 && !just_acked) ? onehot(order[issued]) : 2'b00;
            rd_0_vld   = (returned < issued) && (vld_at[returned] == c);
            rd_0_data  = rd_0_vld ? (RD_BASE + 72'(returned)) : '0;
            #1;
            if (rd_0_vld) begin
                check_eq($sformatf("t3_vld%0d", returned), 128'(req_rd_vld), 128'(onehot(order[returned])));
                check_eq($sformatf("t3_data%0d", returned), 128'(req_rd_data), 128'(RD_BASE + 72'(returned)));
                $display("t3 read data %0d -> vld=%b", returned, req_rd_vld);
                returned++;
            end
            just_acked = 1'b0;
            if (req_rd_ack != 2'b00) begin
                check_eq($sformatf("t3_ack%0d", issued), 128'(req_rd_ack), 128'(onehot(order[issued])));
                check_eq($sformatf("t3_addr%0d", issued), 128'(rd_0_addr), 128'(exp_rd_addr(order[issued])));
                vld_at[issued] = c + 5;
                issued++;
                just_acked = 1'b1;
            end
            @(negedge clk);
        end
        clear_inputs();
        check_eq("t3_issued", 128'(issued), 128'(3));
        check_eq("t3_returned", 128'(returned), 128'(3));

        // 4: eight outstanding reads block the ninth until data returns
        for (int k = 0; k < 8; k++) begin
            rd_one(k % 2);
        end
        req_rd_req = 2'b01;
        rd_0_ack   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("t4_block%0d", k), 128'(rd_0_req), 128'(0));
            @(negedge clk);
        end
        rd_0_vld  = 1'b1;
        rd_0_data = RD_BASE + 72'h40;
        #1;
        check_eq("t4_pop_vld", 128'(req_rd_vld), 128'(2'b01));
        check_eq("t4_pop_noreq", 128'(rd_0_req), 128'(0));
        @(negedge clk);
        rd_0_vld = 1'b0;
        #1;
        check_eq("t4_latch_cycle", 128'(rd_0_req), 128'(0));
        @(negedge clk);
        rd_0_vld = 1'b1;
        #1;
        check_eq("t4_unblocked", 128'(rd_0_req), 128'(1));
        check_eq("t4_push_ack", 128'(req_rd_ack), 128'(2'b01));
        check_eq("t4_same_cycle_pop", 128'(req_rd_vld), 128'(2'b10));
        $display("t4 push and pop in one cycle");
        @(negedge clk);
        clear_inputs();
        rd_one(1);
        req_rd_req = 2'b01;
        rd_0_ack   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq($sformatf("t4_full_again%0d", k), 128'(rd_0_req), 128'(0));
            @(negedge clk);
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            rd_0_vld = 1'b1;
            #1;
            check_eq($sformatf("t4_drain%0d", k), 128'(req_rd_vld), 128'(onehot(k % 2)));
            @(negedge clk);
        end
        rd_0_vld = 1'b0;

        // 5: returned data with nothing outstanding
        #1;
        check_eq("t5_err_before", 128'(tag_err), 128'(0));
        @(negedge clk);
        rd_0_vld = 1'b1;
        #1;
        check_eq("t5_no_vld", 128'(req_rd_vld), 128'(0));
        @(negedge clk);
        rd_0_vld = 1'b0;
        #1;
        check_eq("t5_err_set", 128'(tag_err), 128'(1));
        repeat (3) @(negedge clk);
        #1;
        check_eq("t5_err_sticky", 128'(tag_err), 128'(1));
        $display("t5 tag_err=%0d", tag_err);

        // 6: asynchronous reset while both channels are busy
        do_reset();
        #1;
        check_eq("t6_err_cleared", 128'(tag_err), 128'(0));
        @(negedge clk);
        rd_one(1);
        req_wr_req = 2'b01;
        req_rd_req = 2'b10;
        @(negedge clk);
        #1;
        check_eq("t6_wr_busy", 128'(wr_0_req), 128'(1));
        check_eq("t6_rd_busy", 128'(rd_0_req), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_wr_req_abort", 128'(wr_0_req), 128'(0));
        check_eq("t6_rd_req_abort", 128'(rd_0_req), 128'(0));
        check_eq("t6_wr_addr_abort", 128'(wr_0_addr), 128'(0));
        check_eq("t6_rd_addr_abort", 128'(rd_0_addr), 128'(0));
        $display("t6 reset asserted mid-access");
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        rd_0_vld = 1'b1;
        #1;
        check_eq("t6_stale_no_vld", 128'(req_rd_vld), 128'(0));
        @(negedge clk);
        rd_0_vld = 1'b0;
        #1;
        check_eq("t6_stale_err", 128'(tag_err), 128'(1));

        // Grant statistics: 3 writes and 2 reads to requester 1
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr_one(1);
        end
        for (int k = 0; k < 2; k++) begin
            rd_one(1);
        end
        #1;
`ifdef SRAM_ARB_STATS_EN
        check_eq("stats_cnt1", 128'(grant_cnt[63:32]), 128'(5));
`else
        check_eq("stats_cnt1", 128'(grant_cnt[63:32]), 128'(0));
`endif
        check_eq("stats_cnt0", 128'(grant_cnt[31:0]), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
